sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one asynchronous 32-bit SRAM bank (base or ext RAM) between two requesters: instruction-fetch port (i_*) and data port (d_*).
- Sequences SRAM control strobes (active-low ce/oe/we) and the tri-state data bus with fixed, parameterised cycle timing.
- Returns read data with a single-cycle ack.
- Sits inside system between the CPU memory stages and the external SRAM pins; runs on the memory clock.

Parameters:
ADDR_W, 20, SRAM word-address width
DATA_W, 32, SRAM data width
RD_CYCLES, 2, cycles ce/oe held low before read data is sampled (>=1)
WE_CYCLES, 1, cycles we held low per write (>=1)

Ports:
clk  in  1  memory clock; all logic on posedge
rst  in  1  synchronous reset, active-high
i_req  in  1  fetch read request; held until i_ack
i_addr  in  ADDR_W  fetch word address
i_rdata  out  DATA_W  fetch read data; valid while i_ack=1
i_ack  out  1  one-cycle completion pulse, fetch port
d_req  in  1  data request; held until d_ack
d_we  in  1  1=write, 0=read
d_addr  in  ADDR_W  data word address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  read data; valid while d_ack=1
d_ack  out  1  one-cycle completion pulse, data port
ram_addr  out  ADDR_W  SRAM address
ram_data  inout  DATA_W  SRAM data bus; driven only in write states, else Z
ram_ce  out  1  chip enable, active-low
ram_oe  out  1  output enable, active-low
ram_we  out  1  write enable, active-low
busy  out  1  1 whenever state != IDLE

Behaviour:
- Clocking/reset: one clock (clk), synchronous active-high reset (rst).
- Reset values: state=IDLE; ram_ce=ram_oe=ram_we=1; ram_data=Z; ram_addr=0; i_ack=d_ack=0; i_rdata=d_rdata=0; last_grant=FETCH.
- Reset mid-operation: at the next edge, return to IDLE with all strobes high and the bus released. The in-flight transaction is dropped with no ack.
- Outputs: all strobes and addr are registered; no combinational paths from req to pins.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK.
- IDLE:
  - Requests are accepted only in IDLE.
  - Only one req high: grant it.
  - Both high: grant the port opposite last_grant (round-robin). Because last_grant resets to FETCH, the data port wins the first tie.
  - On grant: latch owner, addr, we, wdata; update last_grant.
- RD (fetch, or data with d_we=0):
  - ce=0, oe=0, we=1, bus Z, for exactly RD_CYCLES cycles.
  - At the edge ending the last RD cycle: capture ram_data into the owner's rdata register, then go to ACK.
- WR_SETUP: 1 cycle; ce=0, oe=1, we=1, bus driven with wdata.
- WR_PULSE: WE_CYCLES cycles; we=0, bus driven.
- WR_HOLD: 1 cycle; we=1, ce=0, bus still driven (data hold time).
- ACK:
  - 1 cycle; ce=oe=we=1, bus Z; owner's ack=1, other ack=0; then IDLE.
  - Requester drops req at the edge ending ACK; req high in the following IDLE is a new request.
- Latency, counting the cycle req is sampled in IDLE as cycle 0:
  - Read: ack in cycle RD_CYCLES+1.
  - Write: ack in cycle WE_CYCLES+3.
  - Minimum back-to-back spacing: one IDLE cycle between transactions.
- Data integrity:
  - rdata holds its last captured value until the next read for that port.
  - The non-owner's req, addr and data changes while busy are ignored.
- Wait counter: width clog2(max(RD_CYCLES,WE_CYCLES))+1; loaded on state entry; counts down to 0.
- Bus direction: ram_data is driven only in WR_SETUP, WR_PULSE and WR_HOLD. Z in every other state, including reset.

Decomposition:
- Shared package sram_pkg:
  - FSM state encoding.
  - Port-ID constants PORT_FETCH=0, PORT_DATA=1.
  - Default timing constants RD_CYCLES_DEF and WE_CYCLES_DEF, reused by system and ram_sim-based benches.
- One sub-module, sram_rr_arb2: 2-way round-robin grant (inputs i_req, d_req, last_grant; output grant id and valid). Purely combinational; last_grant is stored in the parent.

Test Plan:
- Fetch read, defaults: i_req=1, i_addr=0x00004, RAM word=0x3C010001 -> ce/oe low cycles 1-2, i_ack=1 in cycle 3, i_rdata=0x3C010001, d_ack stays 0.
- Data write: d_req=1, d_we=1, d_addr=0x80010, d_wdata=0xDEADBEEF -> we low exactly cycle 2, bus driven cycles 1-3, d_ack in cycle 4; a subsequent data read of 0x80010 returns 0xDEADBEEF.
- Tie arbitration: i_req and d_req both high from reset, each re-requesting immediately after ack -> grant order DATA, FETCH, DATA, FETCH; no port waits more than one transaction.
- Request during busy: i_req raised while a data write is in WR_PULSE -> fetch granted in the IDLE after d_ack; write completes untouched.
- Reset mid-write: rst=1 during WR_PULSE -> next cycle ce=oe=we=1, ram_data=Z, no ack; after release, a new read completes normally.
- Parameter sweep: RD_CYCLES=1 and WE_CYCLES=3 -> read ack in cycle 2; write has we low for 3 cycles, ack in cycle 6.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM encoding, port IDs and default timing for the SRAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_ACK      = 3'd5
    } sram_state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    // Default strobe timing, shared by the system top and ram_sim-based benches.
    localparam int RD_CYCLES_DEF = 2;
    localparam int WE_CYCLES_DEF = 1;

    // Wait-counter width: wide enough to hold the longer of the two strobe phases.
    function automatic int wait_cnt_w(input int rd_cycles, input int we_cycles);
        int m;
        m = (rd_cycles > we_cycles) ? rd_cycles : we_cycles;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: requester-side bundle for the fetch (i_*) and data (d_*) ports.
// Latency: none, wires only.
// Backpressure: each requester holds req (and its address/data) until its one-cycle ack.
//   master: the CPU side, drives req/addr/wdata, receives rdata/ack.
//   slave : the arbiter, receives requests, returns rdata/ack.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    modport master (
        output i_req, i_addr,
        input  i_rdata, i_ack,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ack
    );

    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_ack,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ack
    );
endinterface

// File: rtl/sram_rr_arb2.sv
// sram_rr_arb2: two-way round-robin grant between fetch and data requests.
// Latency: purely combinational; the caller stores last_grant.
// Backpressure: none here; the caller only samples the grant when it is idle.
//   in : i_req, d_req, last_grant   out: grant_id (PORT_FETCH/PORT_DATA), grant_vld
module sram_rr_arb2
    import sram_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant_id,
    output logic grant_vld
);

    always_comb begin
        grant_vld = i_req | d_req;
        grant_id  = PORT_FETCH;
        if (i_req && d_req) begin
            // Contention: the port that did not win last time goes next.
            grant_id = ~last_grant;
        end else if (d_req) begin
            grant_id = PORT_DATA;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one async SRAM bank between fetch and data ports, sequencing ce/oe/we.
// Latency: read ack RD_CYCLES+1 cycles after grant, write ack WE_CYCLES+3; one IDLE between jobs.
// Backpressure: requests are only accepted in IDLE; a requester holds req until its ack pulse.
//   ports: clk, rst (sync, active-high), bus (requester interface, slave side),
//          ram_addr/ram_data/ram_ce/ram_oe/ram_we (SRAM pins, strobes active-low), busy.
module sram_port_arbiter
    import sram_pkg::*;
#(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 32,
    parameter int RD_CYCLES = RD_CYCLES_DEF,
    parameter int WE_CYCLES = WE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    sram_port_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_ce,
    output logic              ram_oe,
    output logic              ram_we,
    output logic              busy
);

    localparam int CNT_W = wait_cnt_w(RD_CYCLES, WE_CYCLES);

    sram_state_t       state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              owner, owner_nxt;
    logic              last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              drive_q;
    logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
    logic              i_ack_q, d_ack_q;

    logic              grant_id, grant_vld;
    logic              take, capture;
    logic              ce_nxt, oe_nxt, we_nxt, drive_nxt;
    logic              i_ack_nxt, d_ack_nxt;

    sram_rr_arb2 u_arb (
        .i_req      (bus.i_req),
        .d_req      (bus.d_req),
        .last_grant (last_grant),
        .grant_id   (grant_id),
        .grant_vld  (grant_vld)
    );

    // Next state plus next pin values. Pins are registered from the next
    // state so they change exactly on state entry with no req->pin path.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        take      = 1'b0;
        capture   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (grant_vld) begin
                    take = 1'b1;
                    if (grant_id == PORT_FETCH || !bus.d_we) begin
                        state_nxt = ST_RD;
                        cnt_nxt   = CNT_W'(RD_CYCLES - 1);
                    end else begin
                        state_nxt = ST_WR_SETUP;
                    end
                end
            end
            ST_RD: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = ST_ACK;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_WR_SETUP: begin
                state_nxt = ST_WR_PULSE;
                cnt_nxt   = CNT_W'(WE_CYCLES - 1);
            end
            ST_WR_PULSE: begin
                if (cnt == '0) begin
                    state_nxt = ST_WR_HOLD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_WR_HOLD:  state_nxt = ST_ACK;
            ST_ACK:      state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase

        owner_nxt = take ? grant_id : owner;

        ce_nxt    = ~(state_nxt inside {ST_RD, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD});
        oe_nxt    = ~(state_nxt == ST_RD);
        we_nxt    = ~(state_nxt == ST_WR_PULSE);
        drive_nxt = state_nxt inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD};
        i_ack_nxt = (state_nxt == ST_ACK) && (owner_nxt == PORT_FETCH);
        d_ack_nxt = (state_nxt == ST_ACK) && (owner_nxt == PORT_DATA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            owner      <= PORT_FETCH;
            last_grant <= PORT_FETCH;
            addr_q     <= '0;
            wdata_q    <= '0;
            drive_q    <= 1'b0;
            ram_ce     <= 1'b1;
            ram_oe     <= 1'b1;
            ram_we     <= 1'b1;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            owner   <= owner_nxt;
            drive_q <= drive_nxt;
            ram_ce  <= ce_nxt;
            ram_oe  <= oe_nxt;
            ram_we  <= we_nxt;
            i_ack_q <= i_ack_nxt;
            d_ack_q <= d_ack_nxt;

            // Address and write data are frozen at grant so the requester
            // (or the losing port) can change its inputs while we are busy.
            if (take) begin
                last_grant <= grant_id;
                addr_q     <= (grant_id == PORT_DATA) ? bus.d_addr : bus.i_addr;
                wdata_q    <= bus.d_wdata;
            end

            // Sample the bus at the edge ending the last oe-low cycle.
            if (capture) begin
                if (owner == PORT_FETCH) begin
                    i_rdata_q <= ram_data;
                end else begin
                    d_rdata_q <= ram_data;
                end
            end
        end
    end

    assign ram_addr    = addr_q;
    assign ram_data    = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign busy        = (state != ST_IDLE);
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.i_ack   = i_ack_q;
    assign bus.d_ack   = d_ack_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: scoreboard bench for two arbiter builds (default timing and RD=1/WE=3).
// Latency: expected ack cycle, rdata and strobe-low counts are queued per port at issue time.
// Backpressure: requesters hold req until ack and drop it at the edge ending ACK.
module tb_sram_port_arbiter;
    import sram_pkg::*;

    localparam int AW = 20;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT 0: default timing ----------------
    sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    logic [AW-1:0] ram_addr0;
    wire  [DW-1:0] ram_data0;
    logic          ram_ce0, ram_oe0, ram_we0, busy0;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_CYCLES(2), .WE_CYCLES(1)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus0),
        .ram_addr (ram_addr0),
        .ram_data (ram_data0),
        .ram_ce   (ram_ce0),
        .ram_oe   (ram_oe0),
        .ram_we   (ram_we0),
        .busy     (busy0)
    );

    // ---------------- DUT 1: RD_CYCLES=1, WE_CYCLES=3 ----------------
    sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    logic [AW-1:0] ram_addr1;
    wire  [DW-1:0] ram_data1;
    logic          ram_ce1, ram_oe1, ram_we1, busy1;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_CYCLES(1), .WE_CYCLES(3)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus1),
        .ram_addr (ram_addr1),
        .ram_data (ram_data1),
        .ram_ce   (ram_ce1),
        .ram_oe   (ram_oe1),
        .ram_we   (ram_we1),
        .busy     (busy1)
    );

    // ---------------- SRAM models ----------------
    logic [DW-1:0] mem0 [logic [AW-1:0]];
    logic [DW-1:0] mem1 [logic [AW-1:0]];
    logic [DW-1:0] rd_word0, rd_word1;

    assign ram_data0 = (!ram_ce0 && !ram_oe0) ? rd_word0 : {DW{1'bz}};
    assign ram_data1 = (!ram_ce1 && !ram_oe1) ? rd_word1 : {DW{1'bz}};

    always @(negedge clk) begin
        if (rst) begin
            mem0[20'h00004] = 32'h3C010001;
            mem0[20'h00008] = 32'h12345678;
        end
        if (!ram_ce0 && !ram_we0) mem0[ram_addr0] = ram_data0;
        if (!ram_ce1 && !ram_we1) mem1[ram_addr1] = ram_data1;
        rd_word0 = mem0.exists(ram_addr0) ? mem0[ram_addr0] : '0;
        rd_word1 = mem1.exists(ram_addr1) ? mem1[ram_addr1] : '0;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        int          ce_n;
        int          oe_n;
        int          we_n;
    } exp_t;

    exp_t q [4][$];   // index = dut*2 + port
    int   ce_c [2];
    int   oe_c [2];
    int   we_c [2];

    task automatic check(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic pop(input int k, input logic [31:0] rd);
        exp_t e;
        int   n;
        n = k / 2;
        if (q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack_q%0d: got ack expected none (cycle %0d)", k, cyc);
        end else begin
            e = q[k].pop_front();
            check($sformatf("ack_cycle_q%0d", k), cyc, e.cyc);
            check($sformatf("rdata_q%0d", k), rd, e.rdata);
            check($sformatf("ce_low_q%0d", k), ce_c[n], e.ce_n);
            check($sformatf("oe_low_q%0d", k), oe_c[n], e.oe_n);
            check($sformatf("we_low_q%0d", k), we_c[n], e.we_n);
        end
    endtask

    task automatic mon(input int n, input logic ia, input logic da,
                       input logic [31:0] ird, input logic [31:0] drd,
                       input logic ce, input logic oe, input logic we);
        if (!ce) ce_c[n]++;
        if (!oe) oe_c[n]++;
        if (!we) we_c[n]++;
        if (ia) pop(n * 2, ird);
        if (da) pop(n * 2 + 1, drd);
        if (ia || da) begin
            ce_c[n] = 0;
            oe_c[n] = 0;
            we_c[n] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                ce_c[i] = 0;
                oe_c[i] = 0;
                we_c[i] = 0;
            end
        end else begin
            mon(0, bus0.i_ack, bus0.d_ack, bus0.i_rdata, bus0.d_rdata, ram_ce0, ram_oe0, ram_we0);
            mon(1, bus1.i_ack, bus1.d_ack, bus1.i_rdata, bus1.d_rdata, ram_ce1, ram_oe1, ram_we1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int n, input bit port, input bit r, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (n == 0) begin
            if (port) begin
                bus0.d_req = r; bus0.d_we = we; bus0.d_addr = a; bus0.d_wdata = wd;
            end else begin
                bus0.i_req = r; bus0.i_addr = a;
            end
        end else begin
            if (port) begin
                bus1.d_req = r; bus1.d_we = we; bus1.d_addr = a; bus1.d_wdata = wd;
            end else begin
                bus1.i_req = r; bus1.i_addr = a;
            end
        end
    endtask

    function automatic bit ack_of(input int n, input bit port);
        if (n == 0) return port ? bus0.d_ack : bus0.i_ack;
        return port ? bus1.d_ack : bus1.i_ack;
    endfunction

    // Called #1 after a posedge; that cycle is cycle 0 of the request.
    task automatic req(input int n, input bit port, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd, input int lat);
        exp_t e;
        bit   rd;
        bit   got;
        int   rc, wc;
        rc = (n == 0) ? 2 : 1;
        wc = (n == 0) ? 1 : 3;
        rd = (port == 1'b0) || !we;
        e.cyc   = cyc + lat;
        e.rdata = exp_rd;
        e.ce_n  = rd ? rc : wc + 2;
        e.oe_n  = rd ? rc : 0;
        e.we_n  = rd ? 0 : wc;
        q[n * 2 + int'(port)].push_back(e);
        drive(n, port, 1'b1, we, a, wd);
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            got = ack_of(n, port);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout_dut%0d_port%0d: got no ack expected ack by cycle %0d", n, port, e.cyc);
        end
        @(posedge clk);
        #1;
        drive(n, port, 1'b0, 1'b0, a, wd);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(0, 1'b1, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ce",      ram_ce0, 1);
        check("rst_oe",      ram_oe0, 1);
        check("rst_we",      ram_we0, 1);
        check("rst_i_ack",   bus0.i_ack, 0);
        check("rst_d_ack",   bus0.d_ack, 0);
        check("rst_i_rdata", bus0.i_rdata, 0);
        check("rst_d_rdata", bus0.d_rdata, 0);
        check("rst_addr",    ram_addr0, 0);
        check("rst_busy",    busy0, 0);
        check("rst_we_dut1", ram_we1, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Tie from reset: DATA, FETCH, DATA, FETCH.
        fork
            begin
                req(0, 1'b0, 1'b0, 20'h00004, '0, 32'h3C010001, 7);
                req(0, 1'b0, 1'b0, 20'h00008, '0, 32'h12345678, 7);
            end
            begin
                req(0, 1'b1, 1'b0, 20'h00008, '0, 32'h12345678, 3);
                req(0, 1'b1, 1'b0, 20'h00004, '0, 32'h3C010001, 7);
            end
        join

        // Single fetch read, d_ack must stay low.
        req(0, 1'b0, 1'b0, 20'h00004, '0, 32'h3C010001, 3);
        // Data write; d_rdata keeps last data-port read.
        req(0, 1'b1, 1'b1, 20'h80010, 32'hDEADBEEF, 32'h3C010001, 4);
        // Read back.
        req(0, 1'b1, 1'b0, 20'h80010, '0, 32'hDEADBEEF, 3);

        // Fetch raised during WR_PULSE of a data write; served after d_ack.
        fork
            req(0, 1'b1, 1'b1, 20'h00010, 32'hCAFEF00D, 32'hDEADBEEF, 4);
            begin
                repeat (2) @(posedge clk);
                #1;
                req(0, 1'b0, 1'b0, 20'h00010, '0, 32'hCAFEF00D, 6);
            end
        join

        // Reset during WR_PULSE: strobes high, no ack, then a clean read.
        drive(0, 1'b1, 1'b1, 1'b1, 20'h00020, 32'h55AA55AA);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_pulse_we", ram_we0, 0);
        @(posedge clk);
        #1;
        drive(0, 1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("midrst_ce",    ram_ce0, 1);
        check("midrst_oe",    ram_oe0, 1);
        check("midrst_we",    ram_we0, 1);
        check("midrst_d_ack", bus0.d_ack, 0);
        check("midrst_busy",  busy0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req(0, 1'b1, 1'b0, 20'h00004, '0, 32'h3C010001, 3);

        // Timing sweep on the RD=1/WE=3 build.
        req(1, 1'b1, 1'b1, 20'h00030, 32'hA5A50003, 32'h00000000, 6);
        req(1, 1'b1, 1'b0, 20'h00030, '0, 32'hA5A50003, 2);
        req(1, 1'b0, 1'b0, 20'h00030, '0, 32'hA5A50003, 2);

        repeat (5) @(posedge clk);
        for (int k = 0; k < 4; k++) check($sformatf("queue_empty_q%0d", k), q[k].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
